regfile_mp: RTL and testbench

Parametrised multi-port register file with a per-register pending scoreboard: the next generation of the CPU's 32×32 register file. It adds configurable data width, depth, and read/write port counts. It adds optional write-to-read forwarding, and pending bits that the issue stage sets when a long-latency write (load) is launched and that retire automatically on writeback. It sits between decode (read ports), issue (scoreboard set) and writeback (write ports).

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 62 ++++++
 rtl/regfile_mp.sv | 109 ++++++++++
 tb/tb_regfile_mp.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file and the
// issue/writeback stages that talk to it.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_DATA_W-1:0] data_t;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits. Issue marks a register pending when a
// long-latency write is launched; any writeback to it clears the bit.
// A set and a clear to one register in the same cycle leave it pending:
// the writeback belongs to an older instruction, the new load is still out.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic                     i_sb_set,
  input  logic [ADDR_W-1:0]        i_sb_addr,
  output logic [(1<<ADDR_W)-1:0]   o_pend,
  output logic                     o_busy_any
);

  localparam int DEPTH = 1 << ADDR_W;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    if (ZERO_REG != 0 && e == 0) begin : g_zero
      // Register 0 is hardwired and can never be pending.
      assign o_pend[e] = 1'b0;
    end else begin : g_bit
      logic w_set;
      logic w_clr;
      logic r_pend;

      assign w_set = i_sb_set && (i_sb_addr == ADDR_W'(e));

      // Any write port targeting this register retires its pending bit.
      always_comb begin
        w_clr = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
          if (i_wr_en[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(e))) begin
            w_clr = 1'b1;
          end
        end
      end

      // Pending bit: set has priority over clear.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pend <= 1'b0;
        end else if (w_set) begin
          r_pend <= 1'b1;
        end else if (w_clr) begin
          r_pend <= 1'b0;
        end
      end

      assign o_pend[e] = r_pend;
    end
  end

  assign o_busy_any = |o_pend;

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read
// forwarding and a pending scoreboard. Read ports are combinational from
// state (and from the current write ports when forwarding is enabled).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic                     busy_any
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0]  w_we;
  logic [DATA_W-1:0] w_wd  [DEPTH];
  logic [DATA_W-1:0] w_mem [DEPTH];
  logic [DEPTH-1:0]  w_pend;

  // Per-entry write decode. Ports are scanned in ascending order so the
  // highest-index port targeting an entry supplies its data; this same
  // result feeds both storage and forwarding.
  always_comb begin
    w_we = '0;
    for (int e = 0; e < DEPTH; e++) begin
      w_wd[e] = '0;
      if (!(ZERO_REG != 0 && e == 0)) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(e))) begin
            w_we[e] = 1'b1;
            w_wd[e] = wr_data[j*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    if (ZERO_REG != 0 && e == 0) begin : g_zero
      // Register 0 has no storage and always reads zero.
      assign w_mem[e] = '0;
    end else begin : g_reg
      logic [DATA_W-1:0] r_q;

      // Storage entry, loaded by the winning write port.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_q <= '0;
        end else if (w_we[e]) begin
          r_q <= w_wd[e];
        end
      end

      assign w_mem[e] = r_q;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_sb_set   (sb_set),
    .i_sb_addr  (sb_addr),
    .o_pend     (w_pend),
    .o_busy_any (busy_any)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;
    logic              w_rb;

    assign w_ra = rd_addr[k*ADDR_W +: ADDR_W];

    // Read mux: forwarded write data wins over storage when enabled. A
    // forwarded register is no longer busy unless issue re-marks it now.
    always_comb begin
      w_rd = w_mem[w_ra];
      w_rb = w_pend[w_ra];
      if (BYPASS != 0 && w_we[w_ra]) begin
        w_rd = w_wd[w_ra];
        w_rb = sb_set && (sb_addr == w_ra);
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = w_rd;
    assign rd_busy[k]                  = w_rb;
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one instance with forwarding, one without, driven
// by the same inputs and compared against an array-based reference model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data1, rd_data0;
  logic [NR-1:0]     rd_busy1, rd_busy0;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;
  logic              busy_any1, busy_any0;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_pend;
  logic [DW-1:0]    exp_q [$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
               .ZERO_REG(1), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_busy(rd_busy1), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
    .busy_any(busy_any1));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
               .ZERO_REG(1), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_busy(rd_busy0), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
    .busy_any(busy_any0));

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [DW-1:0] obs,
                           input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int e = 0; e < DEPTH; e++) m_mem[e] = '0;
    m_pend = '0;
  endtask

  // Expected read of port k under the given forwarding setting.
  task automatic exp_read(input int k, input bit byp,
                          output logic [DW-1:0] d, output logic b);
    logic [AW-1:0] a;
    logic          fwd;
    logic [DW-1:0] fwd_d;
    a = rd_addr[k*AW +: AW];
    fwd = 1'b0;
    fwd_d = '0;
    for (int j = 0; j < NW; j++) begin
      if (wr_en[j] && wr_addr[j*AW +: AW] == a && a != 0) begin
        fwd = 1'b1;
        fwd_d = wr_data[j*DW +: DW];
      end
    end
    if (byp && fwd) begin
      d = fwd_d;
      b = sb_set && (sb_addr == a);
    end else begin
      d = (a == 0) ? '0 : m_mem[a];
      b = (a == 0) ? 1'b0 : m_pend[a];
    end
  endtask

  // Clock-edge update: writes in port order, then clears, then set wins.
  task automatic model_clock();
    logic [AW-1:0] a;
    for (int j = 0; j < NW; j++) begin
      a = wr_addr[j*AW +: AW];
      if (wr_en[j] && a != 0) begin
        m_mem[a]  = wr_data[j*DW +: DW];
        m_pend[a] = 1'b0;
      end
    end
    if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
  endtask

  // Compare every output of both instances with the model.
  task automatic check_now();
    logic [DW-1:0] d;
    logic          b;
    for (int k = 0; k < NR; k++) begin
      exp_read(k, 1'b1, d, b);
      exp_q.push_back(d);
      exp_q.push_back({{(DW-1){1'b0}}, b});
      exp_read(k, 1'b0, d, b);
      exp_q.push_back(d);
      exp_q.push_back({{(DW-1){1'b0}}, b});
    end
    exp_q.push_back({{(DW-1){1'b0}}, |m_pend});
    for (int k = 0; k < NR; k++) begin
      check_val($sformatf("byp rd_data%0d", k), rd_data1[k*DW +: DW], exp_q.pop_front());
      check_val($sformatf("byp rd_busy%0d", k), {{(DW-1){1'b0}}, rd_busy1[k]}, exp_q.pop_front());
      check_val($sformatf("nobyp rd_data%0d", k), rd_data0[k*DW +: DW], exp_q.pop_front());
      check_val($sformatf("nobyp rd_busy%0d", k), {{(DW-1){1'b0}}, rd_busy0[k]}, exp_q.pop_front());
    end
    d = exp_q.pop_front();
    check_val("byp busy_any", {{(DW-1){1'b0}}, busy_any1}, d);
    check_val("nobyp busy_any", {{(DW-1){1'b0}}, busy_any0}, d);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    sb_set = 1'b0; sb_addr = '0;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[port] = 1'b1;
    wr_addr[port*AW +: AW] = a;
    wr_data[port*DW +: DW] = d;
  endtask

  task automatic rd(input int port, input logic [AW-1:0] a);
    rd_addr[port*AW +: AW] = a;
  endtask

  task automatic sb(input logic [AW-1:0] a);
    sb_set = 1'b1;
    sb_addr = a;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic tick();
    check_now();
    @(posedge clk);
    if (!rst) model_clock();
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    rd_addr = '0;
    idle();
    model_reset();
    @(negedge clk);
    settle();
    check_val("reset busy_any", {31'b0, busy_any1}, 32'h0);

    // Release reset with a write already presented.
    @(negedge clk);
    rst = 1'b0;
    wr(0, 5'd1, 32'h1234);
    rd(0, 5'd1);
    rd(1, 5'd2);
    step();
    idle();
    step();

    // Zero register ignores writes and scoreboard marks.
    wr(0, 5'd0, 32'hDEADBEEF);
    sb(5'd0);
    rd(0, 5'd0);
    settle();
    check_val("r0 fwd data", rd_data1[0 +: DW], 32'h0);
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      settle();
      check_val("r0 data", rd_data0[0 +: DW], 32'h0);
      check_val("r0 busy", {31'b0, rd_busy1[0]}, 32'h0);
      tick();
    end

    // Collision: highest port wins.
    wr(0, 5'd5, 32'h11);
    wr(1, 5'd5, 32'h22);
    rd(0, 5'd5);
    settle();
    check_val("collide fwd", rd_data1[0 +: DW], 32'h22);
    tick();
    idle();
    settle();
    check_val("collide stored", rd_data0[0 +: DW], 32'h22);
    tick();

    // Forwarding versus no forwarding.
    wr(0, 5'd7, 32'h1111);
    step();
    idle();
    wr(0, 5'd7, 32'hA5A5);
    rd(1, 5'd7);
    settle();
    check_val("fwd r7 byp", rd_data1[DW +: DW], 32'hA5A5);
    check_val("fwd r7 nobyp", rd_data0[DW +: DW], 32'h1111);
    tick();
    idle();

    // Scoreboard set and writeback.
    sb(5'd3);
    rd(0, 5'd3);
    step();
    idle();
    settle();
    check_val("sb r3 busy", {31'b0, rd_busy1[0]}, 32'h1);
    check_val("sb busy_any", {31'b0, busy_any1}, 32'h1);
    tick();
    wr(1, 5'd3, 32'h42);
    settle();
    check_val("wb r3 byp busy", {31'b0, rd_busy1[0]}, 32'h0);
    check_val("wb r3 byp data", rd_data1[0 +: DW], 32'h42);
    check_val("wb r3 nobyp busy", {31'b0, rd_busy0[0]}, 32'h1);
    tick();
    idle();
    settle();
    check_val("wb r3 nobyp data", rd_data0[0 +: DW], 32'h42);
    check_val("wb r3 nobyp clr", {31'b0, rd_busy0[0]}, 32'h0);
    tick();

    // Set and clear together: set wins.
    sb(5'd9);
    wr(0, 5'd9, 32'h7);
    rd(0, 5'd9);
    settle();
    check_val("setclr byp busy", {31'b0, rd_busy1[0]}, 32'h1);
    tick();
    idle();
    settle();
    check_val("setclr data", rd_data0[0 +: DW], 32'h7);
    check_val("setclr busy", {31'b0, rd_busy0[0]}, 32'h1);
    tick();

    // Asynchronous reset mid-cycle with nonzero contents.
    rd(0, 5'd9);
    rd(1, 5'd5);
    settle();
    rst = 1'b1;
    #1;
    check_val("areset data0", rd_data0[0 +: DW], 32'h0);
    check_val("areset data1", rd_data1[DW +: DW], 32'h0);
    check_val("areset busy", {30'b0, rd_busy1}, 32'h0);
    check_val("areset busy_any", {31'b0, busy_any0}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic, addresses biased low to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      for (int j = 0; j < NW; j++) begin
        wr_en[j] = ($urandom_range(0, 2) != 0);
        wr_addr[j*AW +: AW] = ($urandom_range(0, 1) != 0) ?
                              AW'($urandom_range(0, 5)) : AW'($urandom_range(0, DEPTH-1));
        wr_data[j*DW +: DW] = $urandom;
      end
      for (int k = 0; k < NR; k++) rd(k, AW'($urandom_range(0, 7)));
      sb_set = ($urandom_range(0, 2) == 0);
      sb_addr = AW'($urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_regfile_mp
